// File: rtl/hdmi_flash_sequencer.sv
`default_nettype none
// ============================================================================
// Module : hdmi_flash_sequencer
// Video timing generator with a frame-locked white/black flash scheduler.
// Optional: define HDMI_FLASH_BARS_EN for colour bars on non-flash frames.
// Rev    : 1.0  initial release
// ============================================================================
module hdmi_flash_sequencer #(
  parameter int H_ACTIVE     = 1280,
  parameter int H_FP         = 110,
  parameter int H_SYNC       = 40,
  parameter int H_BP         = 220,
  parameter int V_ACTIVE     = 720,
  parameter int V_FP         = 5,
  parameter int V_SYNC       = 5,
  parameter int V_BP         = 20,
  parameter bit HS_POL       = 1'b1,
  parameter bit VS_POL       = 1'b1,
  parameter int FLASH_PERIOD = 30,
  parameter int FLASH_LEN    = 2
) (
  input  logic        I_rgb_clk,
  input  logic        I_rst,
  input  logic        I_start,
  input  logic        I_stop,
  output logic        O_busy,
  output logic        O_rgb_de,
  output logic        O_rgb_hs,
  output logic        O_rgb_vs,
  output logic [7:0]  O_rgb_r,
  output logic [7:0]  O_rgb_g,
  output logic [7:0]  O_rgb_b,
  output logic [11:0] O_x,
  output logic [11:0] O_y,
  output logic        O_frame_start,
  output logic        O_flash_on,
  output logic [15:0] O_flash_count
);

  localparam logic [11:0] c_h_total  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] c_v_total  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] c_h_active = 12'(H_ACTIVE);
  localparam logic [11:0] c_v_active = 12'(V_ACTIVE);
  localparam logic [11:0] c_hs_start = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] c_hs_end   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] c_vs_start = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] c_vs_end   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] c_flash_len = 16'(FLASH_LEN);
  localparam logic [15:0] c_dark_len  = 16'(FLASH_PERIOD - FLASH_LEN);
`ifdef HDMI_FLASH_BARS_EN
  localparam logic [11:0] c_bar_w    = (H_ACTIVE >= 8) ? 12'(H_ACTIVE / 8) : 12'd1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DARK  = 2'd2,
    ST_FLASH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] h_q, h_d, v_q, v_d;
  logic [15:0] fc_q, fc_d, count_q, count_d;
  logic        stop_pend_q, stop_pend_d;
  logic        busy_q, busy_d, de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        fs_q, fs_d, flash_q, flash_d;
  logic        fb;
`ifdef HDMI_FLASH_BARS_EN
  logic [11:0] bar_quot;
  logic [2:0]  bar_idx;
`endif

  always_comb begin
    h_d = h_q + 12'd1;
    v_d = v_q;
    if (h_q == c_h_total - 12'd1) begin
      h_d = 12'd0;
      v_d = (v_q == c_v_total - 12'd1) ? 12'd0 : v_q + 12'd1;
    end
    fb = (h_q == 12'd0) && (v_q == 12'd0);

    state_d     = state_q;
    fc_d        = fc_q;
    count_d     = count_q;
    stop_pend_d = stop_pend_q | (I_stop && (state_q != ST_IDLE));

    // A stop landing on the boundary cycle itself is deferred a full frame
    // so the frame being entered is never cut short.
    if (state_q == ST_IDLE) begin
      stop_pend_d = 1'b0;
      if (I_start && !I_stop) state_d = ST_ARMED;
    end else if (fb) begin
      stop_pend_d = I_stop;
      if (stop_pend_q) begin
        state_d = ST_IDLE;
        stop_pend_d = 1'b0;
      end else begin
        case (state_q)
          ST_ARMED: begin
            state_d = ST_FLASH;
            fc_d    = 16'd1;
            count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          end
          ST_FLASH: begin
            if (fc_q == c_flash_len) begin
              state_d = ST_DARK;
              fc_d    = 16'd1;
            end else begin
              fc_d = fc_q + 16'd1;
            end
          end
          ST_DARK: begin
            if (fc_q == c_dark_len) begin
              state_d = ST_FLASH;
              fc_d    = 16'd1;
              count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            end else begin
              fc_d = fc_q + 16'd1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // Outputs follow the post-transition state so pixel (0,0) already
    // belongs to the frame that the boundary just opened.
    busy_d  = (state_d != ST_IDLE);
    flash_d = (state_d == ST_FLASH);
    de_d    = (h_q < c_h_active) && (v_q < c_v_active);
    hs_d    = ((h_q >= c_hs_start) && (h_q < c_hs_end)) ? HS_POL : ~HS_POL;
    vs_d    = ((v_q >= c_vs_start) && (v_q < c_vs_end)) ? VS_POL : ~VS_POL;
    x_d     = h_q;
    y_d     = v_q;
    fs_d    = fb;

    r_d = 8'h00;
    g_d = 8'h00;
    b_d = 8'h00;
`ifdef HDMI_FLASH_BARS_EN
    bar_quot = h_q / c_bar_w;
    bar_idx  = (bar_quot > 12'd7) ? 3'd7 : bar_quot[2:0];
`endif
    if (de_d) begin
      if (flash_d) begin
        r_d = 8'hFF;
        g_d = 8'hFF;
        b_d = 8'hFF;
      end
`ifdef HDMI_FLASH_BARS_EN
      else begin
        r_d = {8{~bar_idx[1]}};
        g_d = {8{~bar_idx[2]}};
        b_d = {8{~bar_idx[0]}};
      end
`endif
    end
  end

  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      state_q     <= ST_IDLE;
      h_q         <= 12'd0;
      v_q         <= 12'd0;
      fc_q        <= 16'd0;
      count_q     <= 16'd0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      de_q        <= 1'b0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      r_q         <= 8'h00;
      g_q         <= 8'h00;
      b_q         <= 8'h00;
      x_q         <= 12'd0;
      y_q         <= 12'd0;
      fs_q        <= 1'b0;
      flash_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      fc_q        <= fc_d;
      count_q     <= count_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fs_q        <= fs_d;
      flash_q     <= flash_d;
    end
  end

  assign O_busy        = busy_q;
  assign O_rgb_de      = de_q;
  assign O_rgb_hs      = hs_q;
  assign O_rgb_vs      = vs_q;
  assign O_rgb_r       = r_q;
  assign O_rgb_g       = g_q;
  assign O_rgb_b       = b_q;
  assign O_x           = x_q;
  assign O_y           = y_q;
  assign O_frame_start = fs_q;
  assign O_flash_on    = flash_q;
  assign O_flash_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_flash_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_hdmi_flash_sequencer
// Frame-table driven bench for hdmi_flash_sequencer on a reduced raster.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hdmi_flash_sequencer;

  localparam int HT = 24;   // 16 + 2 + 3 + 3
  localparam int VT = 10;   // 6 + 1 + 2 + 1
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, de, hs, vs, fs, flash_on;
  logic [7:0]  r, g, b;
  logic [11:0] x, y;
  logic [15:0] cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int len;
    int start_at;
    int start2_at;
    int stop_at;
    int busy_from;
    bit flash;
    int cnt;
    bit do_reset;
  } row_t;

  row_t         rows[21];
  logic [69:0]  sb_q[$];

  always #5 clk = ~clk;

  hdmi_flash_sequencer #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .FLASH_PERIOD(4), .FLASH_LEN(1)
  ) dut (
    .I_rgb_clk(clk), .I_rst(rst), .I_start(start), .I_stop(stop),
    .O_busy(busy), .O_rgb_de(de), .O_rgb_hs(hs), .O_rgb_vs(vs),
    .O_rgb_r(r), .O_rgb_g(g), .O_rgb_b(b), .O_x(x), .O_y(y),
    .O_frame_start(fs), .O_flash_on(flash_on), .O_flash_count(cnt)
  );

  function automatic logic [69:0] pack(input logic pbusy, pde, phs, pvs,
                                       input logic [7:0] pr, pg, pb,
                                       input logic [11:0] px, py,
                                       input logic pfs, pfl,
                                       input logic [15:0] pcnt);
    return {pbusy, pde, phs, pvs, pr, pg, pb, px, py, pfs, pfl, pcnt};
  endfunction

  task automatic check(input string name, input int n, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, n, act, exp);
    end
  endtask

  task automatic check_rgb(input string name, input logic [23:0] exp);
    checks++;
    if ({r, g, b} !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, {r, g, b}, exp);
    end
  endtask

  task automatic run_row(input int idx, input row_t rw);
    int          h, v, de_cnt;
    logic        ede, ehs, evs, ebusy;
    logic [7:0]  er, eg, eb;
    logic [69:0] exp, act;
    int          bi;
    string       nm;
    de_cnt = 0;
    nm = $sformatf("row%0d", idx);
    for (int n = 0; n < rw.len; n++) begin
      h = n % HT;
      v = n / HT;
      start = (n == rw.start_at) || (n == rw.start2_at);
      stop  = (n == rw.stop_at);
      ede   = (h < 16) && (v < 6);
      ehs   = (h >= 18) && (h < 21);
      evs   = (v >= 7) && (v < 9);
      ebusy = (n >= rw.busy_from);
      er = 8'h00; eg = 8'h00; eb = 8'h00;
      if (ede && rw.flash) begin
        er = 8'hFF; eg = 8'hFF; eb = 8'hFF;
      end
`ifdef HDMI_FLASH_BARS_EN
      else if (ede) begin
        bi = h / 2;
        er = ((bi % 4) < 2) ? 8'hFF : 8'h00;
        eg = (bi < 4)       ? 8'hFF : 8'h00;
        eb = ((bi % 2) == 0) ? 8'hFF : 8'h00;
      end
`endif
      sb_q.push_back(pack(ebusy, ede, ehs, evs, er, eg, eb, 12'(h), 12'(v),
                          (n == 0), rw.flash, 16'(rw.cnt)));
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      if (de) de_cnt++;
      exp = sb_q.pop_front();
      act = pack(busy, de, hs, vs, r, g, b, x, y, fs, flash_on, cnt);
      check(nm, n, act, exp);
`ifdef HDMI_FLASH_BARS_EN
      if (!rw.flash && v == 1) begin
        if (h == 0)  check_rgb("bar_x0", 24'hFFFFFF);
        if (h == 2)  check_rgb("bar_x2", 24'hFFFF00);
        if (h == 15) check_rgb("bar_x15", 24'h000000);
      end
`endif
    end
    if (rw.len == FR) begin
      checks++;
      if (de_cnt != 96) begin
        failures++;
        $display("FAIL de_count %s got=%0d expected=96", nm, de_cnt);
      end
    end
    if (rw.do_reset) begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1;
        check("reset_hold", k, pack(busy, de, hs, vs, r, g, b, x, y, fs, flash_on, cnt), 70'd0);
      end
      rst = 1'b0;
    end
  endtask

  initial begin
    //          len  st   st2  stop busy fl cnt rst
    rows[0]  = '{FR, -1,  -1,  -1,  FR,  0, 0, 0};
    rows[1]  = '{FR, -1,  -1,  -1,  FR,  0, 0, 0};
    rows[2]  = '{FR, 53,  -1,  -1,  53,  0, 0, 0};
    rows[3]  = '{FR, -1,  -1,  -1,  0,   1, 1, 0};
    rows[4]  = '{FR, -1,  -1,  -1,  0,   0, 1, 0};
    rows[5]  = '{FR, -1,  -1,  -1,  0,   0, 1, 0};
    rows[6]  = '{FR, -1,  -1,  -1,  0,   0, 1, 0};
    rows[7]  = '{FR, -1,  -1,  -1,  0,   1, 2, 0};
    rows[8]  = '{FR, -1,  -1,  -1,  0,   0, 2, 0};
    rows[9]  = '{FR, -1,  -1,  -1,  0,   0, 2, 0};
    rows[10] = '{FR, -1,  -1,  -1,  0,   0, 2, 0};
    rows[11] = '{FR, -1,  -1,  76,  0,   1, 3, 0};
    rows[12] = '{FR, -1,  -1,  -1,  FR,  0, 3, 0};
    rows[13] = '{FR, 30,  -1,  30,  FR,  0, 3, 0};
    rows[14] = '{FR, 10,  100, -1,  10,  0, 3, 0};
    rows[15] = '{130, -1, -1,  -1,  0,   1, 4, 1};
    rows[16] = '{FR, -1,  -1,  -1,  FR,  0, 0, 0};
    rows[17] = '{FR, 5,   -1,  -1,  5,   0, 0, 0};
    rows[18] = '{FR, -1,  -1,  -1,  0,   1, 1, 0};
    rows[19] = '{FR, -1,  -1,  5,   0,   0, 1, 0};
    rows[20] = '{FR, -1,  -1,  -1,  FR,  0, 1, 0};

    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("reset_init", k, pack(busy, de, hs, vs, r, g, b, x, y, fs, flash_on, cnt), 70'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 21; i++) run_row(i, rows[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hdmi_flash_sequencer.md
Name: hdmi_flash_sequencer

Overview:
- Drives the RGB/sync input side of the HDMI TMDS output stage.
- Free-running video timing generator (hs/vs/de, pixel coordinates) plus a frame-locked flash scheduler.
- The scheduler alternates full-white "flash" frames with black frames, so an external photo sensor can measure display lag.
- Sits between the pixel-clock domain top level and the HDMI serializer. All outputs are registered and aligned to each other.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, hsync width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level
- FLASH_PERIOD, 30, frames per flash cycle; must be greater than FLASH_LEN
- FLASH_LEN, 2, white frames per cycle; must be at least 1

Ports:
- I_rgb_clk  in  1  pixel clock; the only clock
- I_rst  in  1  synchronous, active-high reset
- I_start  in  1  single-cycle pulse; arms the flash sequence
- I_stop  in  1  single-cycle pulse; ends the sequence at the next frame boundary
- O_busy  out  1  high whenever the state is not IDLE
- O_rgb_de  out  1  data enable
- O_rgb_hs  out  1  hsync
- O_rgb_vs  out  1  vsync
- O_rgb_r  out  8  red pixel value
- O_rgb_g  out  8  green pixel value
- O_rgb_b  out  8  blue pixel value
- O_x  out  12  current pixel column; valid when O_rgb_de = 1
- O_y  out  12  current line number
- O_frame_start  out  1  one-cycle pulse at pixel (0,0)
- O_flash_on  out  1  high for the whole duration of every flash frame
- O_flash_count  out  16  number of flash frames entered; saturates at 0xFFFF

Behaviour:
- Reset: h = 0, v = 0, state IDLE, O_flash_count = 0.
  - All outputs at reset: O_rgb_de = 0, rgb = 0, O_busy = 0, O_frame_start = 0, O_flash_on = 0.
  - O_rgb_hs = ~HS_POL, O_rgb_vs = ~VS_POL.
  - Reset asserted mid-frame or mid-flash aborts immediately and restarts timing from (0,0).
- Timing:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1650; V_TOTAL = 750 at defaults.
  - h counts 0..H_TOTAL-1. v increments when h wraps, and wraps at V_TOTAL-1 together with h.
- Decode:
  - de = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hs active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- Latency: every output is registered exactly 1 cycle after the counter state it decodes. O_x/O_y are the registered h/v.
- Frame boundary event (FB): the counters are at h = 0, v = 0. O_frame_start pulses on the cycle whose outputs show (0,0).
- FSM states: IDLE, ARMED, DARK, FLASH. State updates only at FB, except IDLE->ARMED.
  - IDLE: I_start -> ARMED on the next cycle.
  - ARMED: at FB -> FLASH; frame counter fc = 1; O_flash_count++.
  - FLASH: at FB, if fc == FLASH_LEN -> DARK with fc = 1; otherwise fc++.
  - DARK: at FB, if fc == FLASH_PERIOD-FLASH_LEN -> FLASH with fc = 1 and O_flash_count++; otherwise fc++.
- Stop handling:
  - I_stop in any non-IDLE state sets a pending flag.
  - At the next FB the state goes to IDLE instead of the normal transition, and the flag clears.
  - The frame currently in progress completes unchanged; a flash frame is never truncated.
- I_start while busy: ignored.
- I_start and I_stop in the same cycle: stop wins. From IDLE, nothing happens.
- Pixel data:
  - FLASH state with de = 1: rgb = FF/FF/FF.
  - Otherwise: rgb = 00/00/00. Blanking is always 0.
- O_flash_on = 1 for every cycle whose outputs belong to a FLASH-state frame, including blanking.
- O_flash_count saturates at 0xFFFF and is cleared only by reset.

Optional Feature:
- Macro: HDMI_FLASH_BARS_EN.
- Defined:
  - Non-flash active pixels show 8 vertical bars of width H_ACTIVE/8.
  - Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black, each channel 00 or FF.
  - Applies in IDLE, ARMED and DARK. FLASH frames remain full white.
- Undefined: non-flash active pixels are black; no bar logic is compiled.

Test Plan:
- Reset then free-run 2 frames:
  - exactly 1650×750 cycles between O_frame_start pulses;
  - hs high for 40 clocks starting at h = 1390;
  - vs high for lines 725..729;
  - 921600 de cycles per frame.
- Hold I_rst for 3 cycles mid-line at h = 500:
  - outputs at reset values during the hold;
  - the first cycle after release shows O_x = 0, O_y = 0, O_frame_start = 1.
- I_start at v = 100 with FLASH_PERIOD = 4, FLASH_LEN = 1:
  - frame pattern after the next FB is W,B,B,B,W,...;
  - O_flash_count reads 1, then 2 at the 5th frame.
- I_stop during a FLASH frame at v = 300:
  - the frame stays white to the end;
  - at the next FB, O_busy = 0, O_flash_on = 0 and rgb = 0.
- I_start and I_stop in the same cycle from IDLE: O_busy stays 0. A second I_start while ARMED: no change to state or count.
- With HDMI_FLASH_BARS_EN defined, IDLE frame: pixel x = 0 gives FF/FF/FF, x = 160 gives FF/FF/00, x = 1279 gives 00/00/00.
